layer_scheduler: RTL

- Top-level sequencer for one convolution layer.
- On `start`, steps through every output channel 0..OC in order. Per channel: kernel/bias load, convolution pass, adder-tree reduction, pooling.
- Drives the control strobes consumed by the kernel loader, conv blocks, adder tree and pool unit, and owns the output-channel index.
- Completion handshakes from conv and pool gate progress, with an abort path back to idle.

---
 rtl/layer_scheduler.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/layer_scheduler.sv
// Per-layer sequencer: walks output channels 0..OC through load, conv, tree and pool phases.
// Optional CONV/POOL watchdog enabled with `define LAYER_SCHED_TIMEOUT_EN.
module layer_scheduler #(
    parameter int unsigned OC          = 15,
    parameter int unsigned CNT_W       = 4,
    parameter int unsigned LOAD_CYCLES = 2,
    parameter int unsigned TREE_LAT    = 3,
    parameter int unsigned TMO_W       = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             conv_done,
    input  logic             pool_done,
    output logic             c_load,
    output logic             conv,
    output logic             tree,
    output logic             pool,
    output logic             cout,
    output logic [CNT_W-1:0] out_c,
    output logic             busy,
    output logic             cout_done,
    output logic             err
);

    localparam int unsigned PH_MAX = (LOAD_CYCLES > TREE_LAT) ? LOAD_CYCLES : TREE_LAT;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CONV,
        S_TREE,
        S_POOL,
        S_NEXT,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PH_W-1:0]   r_ph_cnt;
    logic [PH_W-1:0]   w_ph_cnt_nxt;
    logic [CNT_W-1:0]  r_out_c;
    logic [CNT_W-1:0]  w_out_c_nxt;
    logic              r_c_load;
    logic              r_conv;
    logic              r_tree;
    logic              r_pool;
    logic              r_cout;
    logic              r_busy;
    logic              r_cout_done;
    logic              w_last_ch;
    logic              w_start_ok;
    logic              w_tmo_fire;

    // Reject configurations that cannot be represented.
    if (OC >= (2 ** CNT_W)) begin : g_bad_cnt_w
        $error("layer_scheduler: CNT_W too narrow for OC");
    end
    if ((LOAD_CYCLES < 1) || (TREE_LAT < 1)) begin : g_bad_lat
        $error("layer_scheduler: LOAD_CYCLES and TREE_LAT must be >= 1");
    end

`ifdef LAYER_SCHED_TIMEOUT_EN
    if (TMO_W < 2) begin : g_bad_tmo
        $error("layer_scheduler: TMO_W must be >= 2");
    end

    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W - 1){1'b1}}, 1'b0};

    logic [TMO_W-1:0] r_tmo;
    logic             r_err;

    // Fires on the wait cycle whose increment would reach all-ones.
    assign w_tmo_fire = (r_tmo == TMO_LAST) &&
                        (((r_state == S_CONV) && !conv_done) ||
                         ((r_state == S_POOL) && !pool_done));
    assign w_start_ok = start && !r_err;
    assign err        = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_tmo <= (w_state_nxt == r_state) ? r_tmo + TMO_W'(1) : '0;
            if (abort) begin
                r_err <= 1'b0;
            end else if (w_tmo_fire) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    if (TMO_W == 0) begin : g_bad_tmo
        $error("layer_scheduler: TMO_W must be nonzero");
    end

    assign w_tmo_fire = 1'b0;
    assign w_start_ok = start;
    assign err        = 1'b0;
`endif

    assign w_last_ch = (r_out_c == CNT_W'(OC));

    // Next-state and channel-index decode; abort overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_out_c_nxt = r_out_c;
        case (r_state)
            S_IDLE: if (w_start_ok) w_state_nxt = S_LOAD;
            S_LOAD: if (r_ph_cnt == PH_W'(LOAD_CYCLES - 1)) w_state_nxt = S_CONV;
            S_CONV: begin
                if (conv_done) begin
                    w_state_nxt = S_TREE;
                end else if (w_tmo_fire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_TREE: if (r_ph_cnt == PH_W'(TREE_LAT - 1)) w_state_nxt = S_POOL;
            S_POOL: begin
                if (pool_done) begin
                    w_state_nxt = S_NEXT;
                end else if (w_tmo_fire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_NEXT: begin
                if (w_last_ch) begin
                    w_state_nxt = S_DONE;
                    w_out_c_nxt = '0;
                end else begin
                    w_state_nxt = S_LOAD;
                    w_out_c_nxt = r_out_c + CNT_W'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = S_IDLE;
        end
        if (w_state_nxt == S_IDLE) begin
            w_out_c_nxt = '0;
        end
        w_ph_cnt_nxt = (w_state_nxt == r_state) ? r_ph_cnt + PH_W'(1) : '0;
    end

    // State and outputs registered together, outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ph_cnt    <= '0;
            r_out_c     <= '0;
            r_c_load    <= 1'b0;
            r_conv      <= 1'b0;
            r_tree      <= 1'b0;
            r_pool      <= 1'b0;
            r_cout      <= 1'b0;
            r_busy      <= 1'b0;
            r_cout_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ph_cnt    <= w_ph_cnt_nxt;
            r_out_c     <= w_out_c_nxt;
            r_c_load    <= (w_state_nxt == S_LOAD) && (r_state != S_LOAD);
            r_conv      <= (w_state_nxt == S_CONV);
            r_tree      <= (w_state_nxt == S_TREE);
            r_pool      <= (w_state_nxt == S_POOL);
            r_cout      <= (w_state_nxt == S_NEXT);
            r_busy      <= (w_state_nxt != S_IDLE);
            r_cout_done <= (w_state_nxt == S_DONE);
        end
    end

    assign c_load    = r_c_load;
    assign conv      = r_conv;
    assign tree      = r_tree;
    assign pool      = r_pool;
    assign cout      = r_cout;
    assign out_c     = r_out_c;
    assign busy      = r_busy;
    assign cout_done = r_cout_done;

endmodule
